// File: rtl/freq_lookup_scheduler.sv
// Round-robin scheduler serialising 16 per-channel frequency-table lookups onto the shared sharer port.
// Define FREQ_SCHED_GAP_EN to force an idle cycle after every grant.
module freq_lookup_scheduler #(
    parameter int unsigned NCH = 16,
    parameter int unsigned AW  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH*AW-1:0] req_addr_i,
    output logic [NCH-1:0]    valid_addr_o,
    output logic [NCH*AW-1:0] addr_out_o,
    output logic [NCH-1:0]    done_o,
    output logic [NCH-1:0]    pending_o,
    output logic              busy_o
);

    localparam int unsigned IW = $clog2(NCH);

    // StGrant means a grant is on the registered outputs this cycle.
    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e                   state_q, state_d;
    logic [NCH-1:0]           pending_q, pending_d;
    logic [NCH-1:0]           valid_q, valid_d;
    logic [NCH-1:0]           done_s1_q, done_q;
    logic [NCH-1:0][AW-1:0]   lat_q, lat_d;
    logic [NCH*AW-1:0]        addr_q, addr_d;
    logic [IW-1:0]            last_q, last_d;
    logic [IW-1:0]            cand;
    logic [IW-1:0]            grant_idx;
    logic                     grant_found;
    logic                     can_grant;
    logic                     issue;

    // First pending channel searching upward from last_q+1, wrapping naturally in IW bits.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = last_q + IW'(k);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

`ifdef FREQ_SCHED_GAP_EN
    assign can_grant = (state_q != StGrant);
`else
    assign can_grant = 1'b1;
`endif

    assign issue = can_grant && grant_found;

    always_comb begin
        state_d   = state_q;
        valid_d   = '0;
        addr_d    = addr_q;
        pending_d = pending_q;
        last_d    = last_q;
        lat_d     = lat_q;

        unique case (state_q)
            StIdle, StGap: state_d = issue ? StGrant : StIdle;
            StGrant: begin
`ifdef FREQ_SCHED_GAP_EN
                state_d = StGap;
`else
                state_d = issue ? StGrant : StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            valid_d[grant_idx]            = 1'b1;
            addr_d[grant_idx*AW +: AW]    = lat_q[grant_idx];
            pending_d[grant_idx]          = 1'b0;
            last_d                        = grant_idx;
        end

        // A request in its own grant cycle re-arms the channel with the new address.
        for (int unsigned n = 0; n < NCH; n++) begin
            if (req_i[n]) begin
                lat_d[n]     = req_addr_i[n*AW +: AW];
                pending_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            valid_q   <= '0;
            done_s1_q <= '0;
            done_q    <= '0;
            lat_q     <= '0;
            addr_q    <= '0;
            last_q    <= IW'(NCH - 1);
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            done_s1_q <= valid_q;
            done_q    <= done_s1_q;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
        end
    end

    assign valid_addr_o = valid_q;
    assign addr_out_o   = addr_q;
    assign done_o       = done_q;
    assign pending_o    = pending_q;
    assign busy_o       = |{pending_q, valid_q, done_s1_q, done_q};

endmodule

// File: tb/tb_freq_lookup_scheduler.sv
// Self-checking bench for freq_lookup_scheduler: directed scenarios plus random traffic
// checked every cycle against a behavioural round-robin model.
module tb_freq_lookup_scheduler;

    localparam int NCH = 16;
    localparam int AW  = 10;
`ifdef FREQ_SCHED_GAP_EN
    localparam bit Gap = 1'b1;
`else
    localparam bit Gap = 1'b0;
`endif
    localparam int Step = Gap ? 2 : 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH-1:0]    valid_addr;
    logic [NCH*AW-1:0] addr_out;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    pending;
    logic              busy;

    freq_lookup_scheduler #(.NCH(NCH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .valid_addr_o (valid_addr),
        .addr_out_o   (addr_out),
        .done_o       (done),
        .pending_o    (pending),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit                m_pend[NCH];
    int                m_lat[NCH];
    int                m_last;
    logic [NCH-1:0]    m_valid, m_s1, m_done;
    logic [NCH*AW-1:0] m_addr;

    task automatic check(input string tag, input logic [NCH*AW-1:0] obs,
                         input logic [NCH*AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] pend_vec();
        logic [NCH-1:0] v;
        for (int n = 0; n < NCH; n++) v[n] = m_pend[n];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [NCH-1:0] nv;
        if (rst) begin
            for (int n = 0; n < NCH; n++) begin
                m_pend[n] = 1'b0;
                m_lat[n]  = 0;
            end
            m_last  = NCH - 1;
            m_valid = '0;
            m_s1    = '0;
            m_done  = '0;
            m_addr  = '0;
        end else begin
            nv = '0;
            if (!(Gap && m_valid != 0)) begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_last + k) % NCH;
                    if (m_pend[c]) begin
                        nv[c]               = 1'b1;
                        m_addr[c*AW +: AW]  = AW'(m_lat[c]);
                        m_pend[c]           = 1'b0;
                        m_last              = c;
                        break;
                    end
                end
            end
            for (int n = 0; n < NCH; n++) begin
                if (req[n]) begin
                    m_lat[n]  = int'(req_addr[n*AW +: AW]);
                    m_pend[n] = 1'b1;
                end
            end
            m_done  = m_s1;
            m_s1    = m_valid;
            m_valid = nv;
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] pv;
        model_step();
        @(posedge clk);
        #1;
        pv = pend_vec();
        check("valid_addr", valid_addr, m_valid);
        check("addr_out", addr_out, m_addr);
        check("done", done, m_done);
        check("pending", pending, pv);
        check("busy", busy, |{pv, m_valid, m_s1, m_done});
        check("onehot", $onehot0(valid_addr), 1);
    endtask

    task automatic set_req(input int ch, input int a);
        req[ch]                = 1'b1;
        req_addr[ch*AW +: AW]  = AW'(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && busy; i++) tick();
        check("drain_idle", busy, 0);
    endtask

    initial begin
        int e, first, last, cnt, grants;
        logic [AW-1:0] a;

        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_out", {valid_addr, done, pending, busy}, 0);
            check("idle_addr", addr_out, 0);
        end

        // Single request on channel 3
        set_req(3, 'h155);
        tick();
        req = '0;
        check("single_pend", pending[3], 1);
        tick();
        a = addr_out[3*AW +: AW];
        check("single_valid", valid_addr, 16'h0008);
        check("single_addr", a, 10'h155);
        tick();
        check("single_one_cycle", valid_addr, 0);
        tick();
        check("single_done", done, 16'h0008);
        tick();
        check("single_busy", busy, 0);

        // All channels at once from reset state
        do_reset();
        req = '1;
        for (int n = 0; n < NCH; n++) req_addr[n*AW +: AW] = AW'(n);
        tick();
        req = '0;
        e = 0; first = -1; last = -1;
        for (int cyc = 2; cyc <= 45; cyc++) begin
            tick();
            if (valid_addr != 0) begin
                a = addr_out[e*AW +: AW];
                check("rr_order", valid_addr, 16'(1) << e);
                check("rr_addr", a, AW'(e));
                if (first < 0) first = cyc;
                last = cyc;
                e++;
            end
        end
        check("rr_count", e, 16);
        check("rr_first", first, 2);
        check("rr_last", last, 2 + 15 * Step);

        // Overwrite while waiting behind other channels
        for (int n = 0; n < 5; n++) set_req(n, n + 'h100);
        set_req(5, 'h010);
        tick();
        req = '0;
        set_req(5, 'h020);
        tick();
        req = '0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid_addr[5]) begin
                cnt++;
                a = addr_out[5*AW +: AW];
                check("ovw_addr", a, 10'h020);
            end
        end
        check("ovw_count", cnt, 1);

        // Re-request in the grant decision cycle
        set_req(2, 'h0AA);
        tick();
        req = '0;
        set_req(2, 'h0BB);
        tick();
        req = '0;
        a = addr_out[2*AW +: AW];
        check("rereq_valid1", valid_addr, 16'h0004);
        check("rereq_addr1", a, 10'h0AA);
        check("rereq_pend", pending[2], 1);
        cnt = 0;
        for (int i = 0; i < 6 && cnt == 0; i++) begin
            tick();
            if (valid_addr != 0) cnt++;
        end
        a = addr_out[2*AW +: AW];
        check("rereq_seen", cnt, 1);
        check("rereq_valid2", valid_addr, 16'h0004);
        check("rereq_addr2", a, 10'h0BB);
        drain();

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            req = NCH'($urandom & $urandom & $urandom);
            for (int n = 0; n < NCH; n++) req_addr[n*AW +: AW] = AW'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        drain();

        // Reset in the middle of a full drain
        do_reset();
        req = '1;
        for (int n = 0; n < NCH; n++) req_addr[n*AW +: AW] = AW'(n + 'h200);
        tick();
        req = '0;
        grants = 0;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            tick();
            if (valid_addr != 0) grants++;
        end
        check("mid_grants", grants, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out", {valid_addr, done, pending, busy}, 0);
        check("mid_rst_addr", addr_out, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_quiet", {valid_addr, done}, 0);
        end
        set_req(0, 'h001);
        set_req(15, 'h00F);
        tick();
        req = '0;
        tick();
        check("mid_last15", valid_addr, 16'h0001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
